gpio_in_irq: RTL and testbench
==============================

Name: gpio_in_irq

Overview:
Parametrised GPIO input port with a per-bit synchroniser, a debounce filter, rising/falling edge detection and sticky interrupt flags. It sits on the CPU peripheral bus behind a chip-select, with 4 word registers selected by addr. It samples io_in continuously rather than on access, and drives a single level interrupt request to the interrupt controller.

Parameters:
WIDTH, 32, number of input bits and bus data width
SYNC_STAGES, 2, synchroniser flops per bit (minimum 2)
DEBOUNCE, 0, extra consecutive stable cycles required before the filtered value changes (0 = no filtering)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
cs  input  1  chip select for a bus access
wen  input  1  write enable, qualified by cs
addr  input  2  register select
din  input  WIDTH  write data
dout  output  WIDTH  read data, combinational from addr
io_in  input  WIDTH  asynchronous pin inputs
irq  output  1  interrupt request, level, active-high

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n=0, all flops are cleared: sync chain, filt, debounce counters, FLAGS, RISE_EN and FALL_EN. Resulting reset outputs: dout = 0 for every addr, irq = 0.
- Register map:
  - addr 0 DATA: read-only, returns filt. Writes are ignored.
  - addr 1 FLAGS: read returns the sticky edge flags. Write is write-1-to-clear per bit.
  - addr 2 RISE_EN: read/write per-bit enable for rising-edge flags.
  - addr 3 FALL_EN: read/write per-bit enable for falling-edge flags.
- Read path: dout = mux(addr) with no cs gating and zero latency.
- Write path: takes effect at the clock edge where cs=1 and wen=1.
- Synchroniser: each bit passes through a SYNC_STAGES-deep flop chain; the last stage is sync.
- Debounce, per bit, counter cnt of width max(1, clog2(DEBOUNCE+1)):
  - sync == filt: cnt <= 0.
  - sync != filt and cnt < DEBOUNCE: cnt <= cnt+1.
  - sync != filt and cnt == DEBOUNCE: filt <= sync, cnt <= 0.
  - A pulse at sync shorter than DEBOUNCE+1 cycles never reaches filt.
- Latency: from an io_in change (setup met before edge 1) to the filt/DATA update is SYNC_STAGES + DEBOUNCE + 1 edges.
- Edge detect:
  - rise[i] = filt_next[i] & ~filt[i]; fall[i] = ~filt_next[i] & filt[i].
  - FLAGS[i] sets at the same edge filt changes, if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Flags are sticky until cleared.
- Simultaneous events:
  - A set and a W1C of the same bit in one cycle: set wins, flag stays 1.
  - A W1C of a bit with no event: clears it.
  - A write of 0 to a bit: no effect.
- Enable changes: do not retroactively set or clear existing flags. Disabling an enable does not clear its flag.
- irq = |FLAGS, registered implicitly: irq rises in the cycle after the setting edge's state is visible, and has no extra flop beyond FLAGS.
- Reset mid-operation: clears everything immediately, asynchronously. After release, filt restarts from 0, so a high pin gives DATA=1 after the latency. No flag is produced because the enables are 0.
- DEBOUNCE=0 gives a pure synchronise-and-register path, with no counter behaviour visible.

Test Plan:
1. WIDTH=8, SYNC_STAGES=2, DEBOUNCE=3: after reset, io_in=8'h00 -> 8'h01 -> DATA reads 8'h01 exactly 6 edges after the change (not 5); FLAGS stays 8'h00 because the enables are 0.
2. RISE_EN=8'h01, FALL_EN=8'h00: io_in[0] 0->1 -> FLAGS=8'h01 and irq=1 on the edge DATA updates. Then io_in[0] 1->0 -> FLAGS stays 8'h01. Write FLAGS=8'h01 -> FLAGS=8'h00, irq=0 next cycle.
3. Glitch filtering with DEBOUNCE=3: io_in[2] high for 3 clocks, then low -> DATA[2] never changes and no flag sets. High for 4 clocks -> DATA[2]=1, then 0 after it falls.
4. Simultaneous set/clear: FLAGS[1]=1, FALL_EN[1]=1. Time a W1C of 8'h02 to hit the same edge as a new falling event on bit 1 -> FLAGS[1] remains 1. Write 8'h00 to FLAGS -> no change.
5. Register access: write DATA with 8'hFF -> ignored, DATA still reflects the pins. Write RISE_EN=8'hA5 -> reads 8'hA5. Write with cs=0 -> no update.
6. Async reset: assert reset_n=0 mid-debounce with FLAGS=8'h81 -> dout=0 and irq=0 immediately, without waiting for clk. After release with io_in=8'hFF -> DATA=8'hFF after 6 edges and FLAGS=0.

Source files
------------

// File: rtl/gpio_in_irq_if.sv
// Peripheral bus bundle for gpio_in_irq: chip-select qualified register
// access with a combinational read path.
`timescale 1ns/1ps
interface gpio_in_irq_if #(
  parameter int WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [1:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, output wen, output addr, output din, input dout);
  modport slave  (input cs, input wen, input addr, input din, output dout);
endinterface

// File: rtl/gpio_in_irq.sv
// GPIO input port: per-bit synchroniser, debounce filter, edge detection
// and sticky interrupt flags, with four bus-visible word registers.
`timescale 1ns/1ps
module gpio_in_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_in_irq_if.slave     bus,
  input  logic [WIDTH-1:0] io_in,
  output logic             irq
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_FLAGS   = 2'd1,
    REG_RISE_EN = 2'd2,
    REG_FALL_EN = 2'd3
  } reg_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] rise, fall, set, clr;
  logic             wr;

  assign sync = sync_q[SYNC_STAGES-1];
  assign wr   = bus.cs & bus.wen;

  // Multi-stage synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Debounce: filt follows sync only after DEBOUNCE+1 consecutive differing cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge events, W1C clear and enable updates; a set beats a clear on the same bit
  always_comb begin
    rise      = filt_d & ~filt_q;
    fall      = ~filt_d & filt_q;
    set       = (rise & rise_en_q) | (fall & fall_en_q);
    clr       = (wr && bus.addr == REG_FLAGS) ? bus.din : '0;
    flags_d   = (flags_q & ~clr) | set;
    rise_en_d = (wr && bus.addr == REG_RISE_EN) ? bus.din : rise_en_q;
    fall_en_d = (wr && bus.addr == REG_FALL_EN) ? bus.din : fall_en_q;
  end

  // Filter, counter, flag and enable state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '{default: '0};
      filt_q    <= '0;
      flags_q   <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      flags_q   <= flags_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
    end
  end

  // Read mux: zero latency, not gated by cs
  always_comb begin
    bus.dout = '0;
    case (reg_e'(bus.addr))
      REG_DATA:    bus.dout = filt_q;
      REG_FLAGS:   bus.dout = flags_q;
      REG_RISE_EN: bus.dout = rise_en_q;
      REG_FALL_EN: bus.dout = fall_en_q;
      default:     bus.dout = '0;
    endcase
  end

  // Level interrupt straight from the flag register
  assign irq = |flags_q;

endmodule

// File: tb/tb_gpio_in_irq.sv
// Scoreboard bench for gpio_in_irq (WIDTH=8, SYNC_STAGES=2, DEBOUNCE=3).
// The reference model filters by looking at a window of past pin samples.
`timescale 1ns/1ps
module tb_gpio_in_irq;
  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] io_in = '0;
  logic         irq;
  logic [W-1:0] pins = '0;

  gpio_in_irq_if #(.WIDTH(W)) bus ();

  gpio_in_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_filt, m_flags, m_ren, m_fen;
  logic [W-1:0] hist[$];

  typedef struct {
    logic [W-1:0] dout;
    logic         irq;
  } exp_t;
  exp_t sbq[$];

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_filt = '0; m_flags = '0; m_ren = '0; m_fen = '0;
    hist.delete();
    for (int k = 0; k < S + D + 1; k++) hist.push_back('0);
  endfunction

  function automatic logic [W-1:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_filt;
      2'd1:    return m_flags;
      2'd2:    return m_ren;
      default: return m_fen;
    endcase
  endfunction

  // One clock edge: filt flips when the last D+1 synchronised samples all oppose it.
  function automatic void m_edge(input logic c, input logic w, input logic [1:0] a,
                                 input logic [W-1:0] d, input logic [W-1:0] pin);
    logic [W-1:0] nf, ev, clr;
    logic all_diff;
    hist.push_back(pin);
    void'(hist.pop_front());
    nf = m_filt;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k <= D; k++) if (hist[k][i] == m_filt[i]) all_diff = 1'b0;
      if (all_diff) nf[i] = ~m_filt[i];
    end
    ev  = (nf & ~m_filt & m_ren) | (~nf & m_filt & m_fen);
    clr = (c && w && a == 2'd1) ? d : '0;
    m_flags = (m_flags & ~clr) | ev;
    if (c && w && a == 2'd2) m_ren = d;
    if (c && w && a == 2'd3) m_fen = d;
    m_filt = nf;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic c, input logic w, input logic [1:0] a, input logic [W-1:0] d);
    bus.cs = c; bus.wen = w; bus.addr = a; bus.din = d; io_in = pins;
    if (c && !w) sbq.push_back('{dout: m_read(a), irq: (m_flags != '0)});
    @(posedge clk);
    m_edge(c, w, a, d, pins);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b0, a, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rd(2'($urandom_range(0, 3)));
  endtask

  task automatic peek(input logic [1:0] a, input logic [W-1:0] e, input string nm);
    bus.cs = 1'b0; bus.wen = 1'b0; bus.addr = a;
    #1;
    chk(nm, bus.dout, e);
  endtask

  task automatic pk_irq(input logic e, input string nm);
    chk(nm, W'(irq), W'(e));
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && bus.cs && !bus.wen) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", W'(1), W'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rd_dout", bus.dout, e.dout);
          chk("rd_irq", W'(irq), W'(e.irq));
        end
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.cs = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.din = '0;
    m_reset();
    #1;
    for (int a = 0; a < 4; a++) peek(2'(a), 8'h00, "reset_dout");
    pk_irq(1'b0, "reset_irq");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Latency: DATA changes on the 6th edge after the pin change
    pins = 8'h01;
    rd(2'd0);
    for (int k = 0; k < 4; k++) rd(2'd0);
    peek(2'd0, 8'h00, "lat_edge5");
    rd(2'd0);
    peek(2'd0, 8'h01, "lat_edge6");
    peek(2'd1, 8'h00, "flags_no_en");

    // Rising flag, sticky through a fall, W1C
    pins = 8'h00;
    idle(8);
    wr(2'd2, 8'h01);
    wr(2'd3, 8'h00);
    pins = 8'h01;
    for (int k = 0; k < 5; k++) rd(2'd1);
    pk_irq(1'b0, "irq_edge5");
    rd(2'd1);
    peek(2'd1, 8'h01, "rise_flag");
    pk_irq(1'b1, "irq_edge6");
    pins = 8'h00;
    idle(8);
    peek(2'd1, 8'h01, "flag_sticky");
    wr(2'd1, 8'h01);
    peek(2'd1, 8'h00, "w1c_clear");
    pk_irq(1'b0, "irq_cleared");

    // Glitch filtering on bit 2
    wr(2'd2, 8'h04);
    pins = 8'h04;
    idle(3);
    pins = 8'h00;
    idle(10);
    peek(2'd0, 8'h00, "glitch3_data");
    peek(2'd1, 8'h00, "glitch3_flag");
    pins = 8'h04;
    idle(4);
    pins = 8'h00;
    idle(2);
    peek(2'd0, 8'h04, "pulse4_data");
    peek(2'd1, 8'h04, "pulse4_flag");
    idle(6);
    peek(2'd0, 8'h00, "pulse4_fall");
    wr(2'd1, 8'h04);

    // Set beats simultaneous W1C; writing 0 is a no-op
    wr(2'd2, 8'h02);
    wr(2'd3, 8'h02);
    pins = 8'h02;
    idle(8);
    peek(2'd1, 8'h02, "b1_rise_flag");
    pins = 8'h00;
    rd(2'd0);
    idle(4);
    wr(2'd1, 8'h02);
    peek(2'd0, 8'h00, "b1_fell");
    peek(2'd1, 8'h02, "set_wins");
    wr(2'd1, 8'h00);
    peek(2'd1, 8'h02, "w1c_zero");
    wr(2'd1, 8'h02);
    peek(2'd1, 8'h00, "w1c_after");

    // Register access rules
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    pins = 8'h30;
    idle(8);
    wr(2'd0, 8'hFF);
    peek(2'd0, 8'h30, "data_ro");
    wr(2'd2, 8'hA5);
    peek(2'd2, 8'hA5, "rise_en_rw");
    step(1'b0, 1'b1, 2'd2, 8'h5A);
    peek(2'd2, 8'hA5, "cs0_nowrite");

    // Asynchronous reset mid-debounce
    wr(2'd2, 8'h81);
    pins = 8'h81;
    idle(8);
    peek(2'd1, 8'h81, "flags_81");
    pins = 8'hFF;
    idle(3);
    reset_n = 1'b0;
    #1;
    peek(2'd0, 8'h00, "arst_data");
    peek(2'd1, 8'h00, "arst_flags");
    peek(2'd2, 8'h00, "arst_rise_en");
    pk_irq(1'b0, "arst_irq");
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) rd(2'd0);
    peek(2'd0, 8'h00, "rel_edge5");
    rd(2'd0);
    peek(2'd0, 8'hFF, "rel_edge6");
    peek(2'd1, 8'h00, "rel_flags");

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) pins = pins ^ W'(1 << $urandom_range(0, W - 1));
      r = $urandom_range(0, 9);
      if (r < 6)       rd(2'($urandom_range(0, 3)));
      else if (r < 8)  wr(2'($urandom_range(2, 3)), W'($urandom));
      else if (r < 9)  wr(2'd1, W'($urandom));
      else             wr(2'($urandom_range(0, 3)), W'($urandom));
    end

    step(1'b0, 1'b0, 2'd0, '0);
    @(negedge clk);
    #1;
    chk("sb_drained", W'(sbq.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
